// File: rtl/pipe_fifo_reg.sv
// Elastic pipeline FIFO stage: circular buffer with occupancy counter and flush.
// Define PIPE_FIFO_REG_BYPASS_EN for a zero-latency path when the buffer is empty.
module pipe_fifo_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         pin_valid,
    input  logic [DATA_WIDTH-1:0]        pin_data,
    output logic                         pin_ready,
    output logic                         pout_valid,
    output logic [DATA_WIDTH-1:0]        pout_data,
    input  logic                         pout_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  bypass_take;
    logic [DATA_WIDTH-1:0] head_data;

    assign empty     = (count_q == '0);
    assign pin_ready = (count_q < DEPTH_C);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

`ifdef PIPE_FIFO_REG_BYPASS_EN
    logic bypass_hit;

    // Empty buffer: the incoming word is presented straight through.
    assign bypass_hit  = empty && pin_valid && !flush_i;
    assign pout_valid  = bypass_hit || (!empty && !flush_i);
    assign pout_data   = bypass_hit ? pin_data : head_data;
    assign bypass_take = bypass_hit && pout_ready;
`else
    assign pout_valid  = !empty && !flush_i;
    assign pout_data   = head_data;
    assign bypass_take = 1'b0;
`endif

    // A word consumed through the bypass never touches storage.
    assign push = pin_valid && pin_ready && !flush_i && !bypass_take;
    assign pop  = !empty && pout_valid && pout_ready && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; occupancy alone decides what is valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= pin_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_fifo_reg.sv
// Bench for pipe_fifo_reg: a DEPTH=2 and a DEPTH=3 instance checked by scoreboards.
module tb_pipe_fifo_reg;

    logic clk;
    logic rst_n;
    int   tests_run = 0;
    int   failed    = 0;

    logic       a_flush, a_pin_valid, a_pin_ready, a_pout_valid, a_pout_ready;
    logic [7:0] a_pin_data, a_pout_data;
    logic [1:0] a_count;
    logic       b_flush, b_pin_valid, b_pin_ready, b_pout_valid, b_pout_ready;
    logic [7:0] b_pin_data, b_pout_data;
    logic [1:0] b_count;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] b_out[$];
    logic [7:0] exp_a, exp_b;

    pipe_fifo_reg #(.DATA_WIDTH(8), .DEPTH(2)) u_a (
        .clk_i(clk), .rst_i(rst_n), .flush_i(a_flush),
        .pin_valid(a_pin_valid), .pin_data(a_pin_data), .pin_ready(a_pin_ready),
        .pout_valid(a_pout_valid), .pout_data(a_pout_data), .pout_ready(a_pout_ready),
        .count_o(a_count)
    );

    pipe_fifo_reg #(.DATA_WIDTH(8), .DEPTH(3)) u_b (
        .clk_i(clk), .rst_i(rst_n), .flush_i(b_flush),
        .pin_valid(b_pin_valid), .pin_data(b_pin_data), .pin_ready(b_pin_ready),
        .pout_valid(b_pout_valid), .pout_data(b_pout_data), .pout_ready(b_pout_ready),
        .count_o(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboards: accepted words are queued, delivered words are popped and compared.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_flush) begin
                qa.delete();
            end else begin
                if (a_pin_valid && a_pin_ready) qa.push_back(a_pin_data);
                if (a_pout_valid && a_pout_ready) begin
                    tests_run++;
                    if (qa.size() == 0) begin
                        failed++;
                        $display("FAIL a_order: got 0x%02h, required no output", a_pout_data);
                    end else begin
                        exp_a = qa.pop_front();
                        $display("[TB] a out 0x%02h (exp 0x%02h)", a_pout_data, exp_a);
                        if (a_pout_data !== exp_a) begin
                            failed++;
                            $display("FAIL a_order: got 0x%02h, required 0x%02h", a_pout_data, exp_a);
                        end
                    end
                end
            end
            if (b_flush) begin
                qb.delete();
            end else begin
                if (b_pin_valid && b_pin_ready) qb.push_back(b_pin_data);
                if (b_pout_valid && b_pout_ready) begin
                    tests_run++;
                    b_out.push_back(b_pout_data);
                    if (qb.size() == 0) begin
                        failed++;
                        $display("FAIL b_order: got 0x%02h, required no output", b_pout_data);
                    end else begin
                        exp_b = qb.pop_front();
                        $display("[TB] b out 0x%02h (exp 0x%02h)", b_pout_data, exp_b);
                        if (b_pout_data !== exp_b) begin
                            failed++;
                            $display("FAIL b_order: got 0x%02h, required 0x%02h", b_pout_data, exp_b);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_flush = 0; a_pin_valid = 0; a_pin_data = 0; a_pout_ready = 0;
        b_flush = 0; b_pin_valid = 0; b_pin_data = 0; b_pout_ready = 0;
        tick();
        tests_run++;
        if (a_pin_ready !== 1'b1 || a_pout_valid !== 1'b0 || a_pout_data !== 8'h00 || a_count !== 2'd0) begin
            failed++;
            $display("FAIL reset_a: got rdy=%b vld=%b data=0x%02h cnt=%0d, required 1 0 0x00 0",
                     a_pin_ready, a_pout_valid, a_pout_data, a_count);
        end
        tests_run++;
        if (b_pin_ready !== 1'b1 || b_pout_valid !== 1'b0 || b_pout_data !== 8'h00 || b_count !== 2'd0) begin
            failed++;
            $display("FAIL reset_b: got rdy=%b vld=%b data=0x%02h cnt=%0d, required 1 0 0x00 0",
                     b_pin_ready, b_pout_valid, b_pout_data, b_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] words [3];
        logic       rdy_exp [3];
        words   = '{8'hA1, 8'hB2, 8'hC3};
        rdy_exp = '{1'b1, 1'b1, 1'b0};
        a_pout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_pin_valid = 1'b1;
            a_pin_data  = words[i];
            #1;
            tests_run++;
            if (a_pin_ready !== rdy_exp[i]) begin
                failed++;
                $display("FAIL fill_ready[%0d]: got %b, required %b", i, a_pin_ready, rdy_exp[i]);
            end
            if (i > 0) begin
                tests_run++;
                if (a_pout_valid !== 1'b1 || a_pout_data !== 8'hA1) begin
                    failed++;
                    $display("FAIL fill_head[%0d]: got vld=%b data=0x%02h, required 1 0xA1", i, a_pout_valid, a_pout_data);
                end
            end
            tick();
        end
        a_pin_valid = 1'b0;
        #1;
        tests_run++;
        if (a_count !== 2'd2 || a_pout_data !== 8'hA1 || a_pin_ready !== 1'b0) begin
            failed++;
            $display("FAIL fill_full: got cnt=%0d data=0x%02h rdy=%b, required 2 0xA1 0", a_count, a_pout_data, a_pin_ready);
        end
        tick();
    endtask

    task automatic test_full_pop();
        a_pout_ready = 1'b1;
        a_pin_valid  = 1'b1;
        a_pin_data   = 8'hD4;
        #1;
        tests_run++;
        if (a_pin_ready !== 1'b0 || a_pout_data !== 8'hA1) begin
            failed++;
            $display("FAIL full_pop_same: got rdy=%b data=0x%02h, required 0 0xA1", a_pin_ready, a_pout_data);
        end
        tick();
        a_pin_valid  = 1'b0;
        a_pout_ready = 1'b0;
        #1;
        tests_run++;
        if (a_pin_ready !== 1'b1 || a_count !== 2'd1 || a_pout_data !== 8'hB2) begin
            failed++;
            $display("FAIL full_pop_next: got rdy=%b cnt=%0d data=0x%02h, required 1 1 0xB2", a_pin_ready, a_count, a_pout_data);
        end
        tick();
    endtask

    task automatic test_flush();
        a_pin_valid = 1'b1;
        a_pin_data  = 8'hE5;
        tick();
        a_flush    = 1'b1;
        a_pin_data = 8'h55;
        #1;
        tests_run++;
        if (a_count !== 2'd2 || a_pout_valid !== 1'b0) begin
            failed++;
            $display("FAIL flush_cycle: got cnt=%0d vld=%b, required 2 0", a_count, a_pout_valid);
        end
        tick();
        a_flush      = 1'b0;
        a_pin_valid  = 1'b0;
        a_pout_ready = 1'b1;
        #1;
        tests_run++;
        if (a_count !== 2'd0 || a_pout_valid !== 1'b0 || a_pout_data !== 8'h00) begin
            failed++;
            $display("FAIL flush_after: got cnt=%0d vld=%b data=0x%02h, required 0 0 0x00", a_count, a_pout_valid, a_pout_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (a_pout_valid !== 1'b0) begin
                failed++;
                $display("FAIL flush_drop[%0d]: got vld=%b data=0x%02h, required vld 0", i, a_pout_valid, a_pout_data);
            end
        end
        a_pout_ready = 1'b0;
    endtask

    task automatic test_stream();
        int idx = 0;
        int cyc;
        b_out.delete();
        for (cyc = 0; cyc < 200 && b_out.size() < 10; cyc++) begin
            b_pin_valid  = (idx < 10);
            b_pin_data   = 8'(idx);
            b_pout_ready = cyc[0];
            #1;
            if (b_pin_valid && b_pin_ready) idx++;
            tests_run++;
            if (b_count > 2'd3) begin
                failed++;
                $display("FAIL stream_count: got %0d, required <= 3", b_count);
            end
            tick();
        end
        b_pin_valid  = 1'b0;
        b_pout_ready = 1'b0;
        tests_run++;
        if (b_out.size() != 10) begin
            failed++;
            $display("FAIL stream_len: got %0d words, required 10", b_out.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                tests_run++;
                if (b_out[k] !== 8'(k)) begin
                    failed++;
                    $display("FAIL stream_seq[%0d]: got 0x%02h, required 0x%02h", k, b_out[k], 8'(k));
                end
            end
        end
        #1;
    endtask

    task automatic test_latency();
        b_pin_valid  = 1'b1;
        b_pin_data   = 8'h3C;
        b_pout_ready = 1'b1;
        #1;
        tests_run++;
`ifdef PIPE_FIFO_REG_BYPASS_EN
        if (b_pout_valid !== 1'b1 || b_pout_data !== 8'h3C || b_count !== 2'd0) begin
            failed++;
            $display("FAIL latency_same: got vld=%b data=0x%02h cnt=%0d, required 1 0x3C 0", b_pout_valid, b_pout_data, b_count);
        end
`else
        if (b_pout_valid !== 1'b0 || b_count !== 2'd0) begin
            failed++;
            $display("FAIL latency_same: got vld=%b cnt=%0d, required 0 0", b_pout_valid, b_count);
        end
`endif
        tick();
        b_pin_valid = 1'b0;
        #1;
        tests_run++;
`ifdef PIPE_FIFO_REG_BYPASS_EN
        if (b_pout_valid !== 1'b0 || b_count !== 2'd0) begin
            failed++;
            $display("FAIL latency_next: got vld=%b cnt=%0d, required 0 0", b_pout_valid, b_count);
        end
`else
        if (b_pout_valid !== 1'b1 || b_pout_data !== 8'h3C || b_count !== 2'd1) begin
            failed++;
            $display("FAIL latency_next: got vld=%b data=0x%02h cnt=%0d, required 1 0x3C 1", b_pout_valid, b_pout_data, b_count);
        end
`endif
        tick();
        tests_run++;
        if (b_pout_valid !== 1'b0 || b_count !== 2'd0) begin
            failed++;
            $display("FAIL latency_drain: got vld=%b cnt=%0d, required 0 0", b_pout_valid, b_count);
        end
        b_pout_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_pout_ready = 1'b0;
        a_pin_valid  = 1'b1;
        a_pin_data   = 8'h11;
        tick();
        a_pin_data = 8'h22;
        tick();
        rst_n      = 1'b0;
        a_flush    = 1'b1;
        a_pin_data = 8'h77;
        #1;
        tests_run++;
        if (a_count !== 2'd2) begin
            failed++;
            $display("FAIL reset_mid_pre: got cnt=%0d, required 2", a_count);
        end
        tick();
        rst_n        = 1'b1;
        a_flush      = 1'b0;
        a_pin_valid  = 1'b0;
        a_pout_ready = 1'b1;
        #1;
        tests_run++;
        if (a_count !== 2'd0 || a_pout_valid !== 1'b0 || a_pout_data !== 8'h00 || a_pin_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_mid: got cnt=%0d vld=%b data=0x%02h rdy=%b, required 0 0 0x00 1",
                     a_count, a_pout_valid, a_pout_data, a_pin_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (a_pout_valid !== 1'b0) begin
                failed++;
                $display("FAIL reset_mid_drop[%0d]: got vld=%b, required 0", i, a_pout_valid);
            end
        end
        a_pout_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pop();
        test_flush();
        test_stream();
        test_latency();
        test_reset_mid();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
